// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with r0 hard-wired to zero and a busy scoreboard; define RF_BYPASS_EN for same-cycle write forwarding
module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [XLEN-1:0]   wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [XLEN-1:0]   wd1,
  input  logic [NRD*AW-1:0] rs,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREG-1:0]   busy_vec
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  // next state: port 1 write lands last so it wins; issue set lands after write-back clear so it wins
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we0 && wa0 != '0) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (we1 && wa1 != '0) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    regs_d[0] = '0;
  end
  // state registers with synchronous reset overriding writes and issues
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  // combinational read ports, optionally forwarding same-cycle write data
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      rdata[k*XLEN +: XLEN] = regs_q[rs[k*AW +: AW]];
      rbusy[k] = busy_q[rs[k*AW +: AW]];
`ifdef RF_BYPASS_EN
      if (rs[k*AW +: AW] != '0 && we0 && wa0 == rs[k*AW +: AW]) begin
        rdata[k*XLEN +: XLEN] = wd0;
        rbusy[k] = 1'b0;
      end
      if (rs[k*AW +: AW] != '0 && we1 && wa1 == rs[k*AW +: AW]) begin
        rdata[k*XLEN +: XLEN] = wd1;
        rbusy[k] = 1'b0;
      end
`endif
    end
  end
  assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus randomized run against an array-based reference model
module tb_regfile_mp;
`ifdef RF_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, we0, we1, iss_valid;
  logic [4:0] wa0, wa1, iss_rd;
  logic [63:0] wd0, wd1;
  logic [9:0] rs;
  logic [127:0] rdata;
  logic [1:0] rbusy;
  logic [31:0] busy_vec;
  int total = 0;
  int bad = 0;
  logic [63:0] m_reg [32];
  bit m_busy [32];

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs(rs), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, we0; logic [4:0] wa0; logic [63:0] wd0;
    logic we1; logic [4:0] wa1; logic [63:0] wd1;
    logic iv; logic [4:0] ir; logic [4:0] r0, r1;
    logic chk; logic [63:0] e0, e1; logic [31:0] eb; logic [1:0] erb;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e0w, input logic [4:0] a0, input logic [63:0] d0,
                              input logic e1w, input logic [4:0] a1, input logic [63:0] d1,
                              input logic iv, input logic [4:0] ir, input logic [4:0] s0, input logic [4:0] s1,
                              input logic c, input logic [63:0] x0, input logic [63:0] x1,
                              input logic [31:0] xb, input logic [1:0] xrb);
    vec_t v;
    v = '{r, e0w, a0, d0, e1w, a1, d1, iv, ir, s0, s1, c, x0, x1, xb, xrb};
    return v;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 64'h0;
    if (BP && we1 && wa1 == a) return wd1;
    if (BP && we0 && wa0 == a) return wd0;
    return m_reg[a];
  endfunction

  function automatic logic exp_rb(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (BP && ((we0 && wa0 == a) || (we1 && wa1 == a))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_bv();
    logic [31:0] b;
    for (int r = 0; r < 32; r++) b[r] = m_busy[r];
    return b;
  endfunction

  // architectural effect of one clock edge with the currently driven inputs
  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r] = 64'h0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        bit wb = (we0 && wa0 == r) || (we1 && wa1 == r);
        bit is = iss_valid && iss_rd == r;
        if (we1 && wa1 == r) m_reg[r] = wd1;
        else if (we0 && wa0 == r) m_reg[r] = wd0;
        m_busy[r] = is || (m_busy[r] && !wb);
      end
    end
  endtask

  localparam logic [63:0] DB = 64'hDEADBEEFCAFEBABE;
  localparam logic [63:0] NV = 64'h123456789ABCDEF0;
  localparam logic [31:0] B7 = 32'h80;
  localparam logic [31:0] B79 = 32'h280;

  initial begin
    rst = 1'b1; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    iss_valid = 0; iss_rd = 0; rs = 0;
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 0, 0,0, 0, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 0, 0,0, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 1,2, 1, 0,0, 0, 0));
    tbl.push_back(mk(0, 1,1,DB, 0,0,0, 0,0, 1,0, 1, BP ? DB : 64'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 1,0, 1, DB,0, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 1,0,'1, 0,0, 0,1, 1, 0,DB, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 1, 0,0, 0, 0));
    tbl.push_back(mk(0, 1,5,64'h1111, 1,5,64'h2222, 0,0, 5,5, 1, BP ? 64'h2222 : 64'h0, BP ? 64'h2222 : 64'h0, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 5,1, 1, 64'h2222,DB, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,7, 7,0, 1, 0,0, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7,0, 1, 0,0, B7, 2'b01));
    tbl.push_back(mk(0, 1,7,64'h77, 0,0,0, 0,0, 7,0, 1, BP ? 64'h77 : 64'h0, 0, B7, BP ? 2'b00 : 2'b01));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7,0, 1, 64'h77,0, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 1,7,64'h88, 1,7, 7,0, 1, BP ? 64'h88 : 64'h77, 0, 0, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7,0, 1, 64'h88,0, B7, 2'b01));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 0,0, 1, 0,0, B7, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,7, 1, 0,64'h88, B7, 2'b10));
    tbl.push_back(mk(0, 1,9,64'hAAAA, 0,0,0, 0,0, 9,9, 1, BP ? 64'hAAAA : 64'h0, BP ? 64'hAAAA : 64'h0, B7, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,9, 0,0, 1, 0,0, B7, 0));
    tbl.push_back(mk(0, 1,9,NV, 0,0,0, 0,0, 9,9, 1, BP ? NV : 64'hAAAA, BP ? NV : 64'hAAAA, B79, BP ? 2'b00 : 2'b11));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 9,7, 1, NV,64'h88, B7, 2'b10));
    tbl.push_back(mk(1, 1,3,64'h5, 0,0,0, 1,3, 9,7, 1, NV,64'h88, B7, 2'b10));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 3,7, 1, 0,0, 0, 0));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      iss_valid = tbl[i].iv; iss_rd = tbl[i].ir; rs = {tbl[i].r1, tbl[i].r0};
      #3;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d rdata0", i), rdata[63:0], tbl[i].e0);
        check($sformatf("vec%0d rdata1", i), rdata[127:64], tbl[i].e1);
        check($sformatf("vec%0d busy_vec", i), {32'h0, busy_vec}, {32'h0, tbl[i].eb});
        check($sformatf("vec%0d rbusy", i), {62'h0, rbusy}, {62'h0, tbl[i].erb});
      end
      @(posedge clk);
      #1;
    end
    // every address reads zero after reset
    rst = 0; we0 = 0; we1 = 0; iss_valid = 0;
    for (int a = 0; a < 32; a++) begin
      rs = {5'(31 - a), 5'(a)};
      #1;
      check($sformatf("post-reset r%0d", a), rdata[63:0], 64'h0);
      check($sformatf("post-reset r%0d", 31 - a), rdata[127:64], 64'h0);
    end
    check("post-reset busy_vec", {32'h0, busy_vec}, 64'h0);
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = 64'h0;
      m_busy[r] = 1'b0;
    end
    // randomized traffic with small-address bias to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      we0 = $urandom_range(0, 1);
      we1 = $urandom_range(0, 1);
      wa0 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wa1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd0 = {$urandom, $urandom};
      wd1 = {$urandom, $urandom};
      iss_valid = $urandom_range(0, 1);
      iss_rd = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rs = {5'($urandom_range(0, 7)), 5'($urandom)};
      #3;
      check("rnd rdata0", rdata[63:0], exp_rd(rs[4:0]));
      check("rnd rdata1", rdata[127:64], exp_rd(rs[9:5]));
      check("rnd rbusy", {62'h0, rbusy}, {62'h0, exp_rb(rs[9:5]), exp_rb(rs[4:0])});
      check("rnd busy_vec", {32'h0, busy_vec}, {32'h0, exp_bv()});
      @(posedge clk);
      model_edge();
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
